// File: rtl/pattern_tx_if.sv
// rtl/pattern_tx_if.sv - load/payload request and serial line bundle for pattern_tx
interface pattern_tx_if #(
    parameter int DATA_W = 8
);
    logic              load;
    logic [DATA_W-1:0] din;
    logic              c;
    logic              busy;
    logic              done;

    // Producer side: requests frames and watches the line.
    modport master (
        output load,
        output din,
        input  c,
        input  busy,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  load,
        input  din,
        output c,
        output busy,
        output done
    );
endinterface

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - "0110"-preamble serial frame transmitter (parity bit with PATTERN_TX_PARITY_EN)
module pattern_tx #(
    parameter int DATA_W = 8
) (
    input  logic         ck,
    input  logic         rs,
    pattern_tx_if.slave  bus
);

    // Counter must reach 3 in PRE and DATA_W-1 in DATA.
    localparam int CNT_W = (DATA_W > 4) ? $clog2(DATA_W) : 2;
    localparam logic [CNT_W-1:0] LAST_PRE  = CNT_W'(3);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    // Bit i of this constant is sent at preamble index i.
    localparam logic [3:0] PREAMBLE = 4'b0110;

`ifdef PATTERN_TX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_PAR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA} state_t;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] sh_q,    sh_d;
    logic              c_q,     c_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
`ifdef PATTERN_TX_PARITY_EN
    logic              par_q,   par_d;
`endif

    // Next-state logic: every output value is computed one edge ahead so c/busy/done come straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                c_d    = 1'b1;
                busy_d = 1'b0;
                if (bus.load) begin
                    sh_d    = bus.din;
`ifdef PATTERN_TX_PARITY_EN
                    par_d   = ^bus.din;
`endif
                    state_d = S_PRE;
                    cnt_d   = '0;
                    c_d     = PREAMBLE[0];
                    busy_d  = 1'b1;
                end
            end
            S_PRE: begin
                if (cnt_q == LAST_PRE) begin
                    // First payload bit goes out now; the register shifts so its MSB is always the next bit.
                    state_d = S_DATA;
                    cnt_d   = '0;
                    c_d     = sh_q[DATA_W-1];
                    sh_d    = sh_q << 1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    c_d   = PREAMBLE[cnt_d[1:0]];
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_DATA) begin
                    cnt_d = '0;
`ifdef PATTERN_TX_PARITY_EN
                    state_d = S_PAR;
                    c_d     = par_q;
`else
                    state_d = S_IDLE;
                    c_d     = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    c_d   = sh_q[DATA_W-1];
                    sh_d  = sh_q << 1;
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            S_PAR: begin
                state_d = S_IDLE;
                c_d     = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                c_d     = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts a frame at once with the line back high and no done pulse.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            c_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PATTERN_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.c    = c_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - self-checking bench for pattern_tx against a frame-queue model
module tb_pattern_tx;

    localparam int W = 8;
`ifdef PATTERN_TX_PARITY_EN
    localparam int F = 5 + W;
`else
    localparam int F = 4 + W;
`endif

    logic ck = 1'b0;
    logic rs;

    pattern_tx_if #(.DATA_W(W)) bus ();

    pattern_tx #(.DATA_W(W)) dut (
        .ck  (ck),
        .rs  (rs),
        .bus (bus.slave)
    );

    always #5 ck = ~ck;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model: bits still to appear on the line, front = bit currently shown.
    bit m_q[$];
    bit m_done;
    int done_log[$];

    function automatic void build_frame(input logic [W-1:0] d);
        m_q.delete();
        m_q.push_back(1'b0);
        m_q.push_back(1'b1);
        m_q.push_back(1'b1);
        m_q.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) m_q.push_back(d[i]);
`ifdef PATTERN_TX_PARITY_EN
        m_q.push_back(^d);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("c",    {31'd0, bus.c},    {31'd0, (m_q.size() > 0) ? m_q[0] : 1'b1});
        chk("busy", {31'd0, bus.busy}, {31'd0, m_q.size() > 0});
        chk("done", {31'd0, bus.done}, {31'd0, m_done});
    endtask

    // Advance the model by the rules for the coming edge, clock once, then compare.
    task automatic step();
        if (rs) begin
            m_q.delete();
            m_done = 1'b0;
        end else if (m_q.size() > 0) begin
            void'(m_q.pop_front());
            m_done = (m_q.size() == 0);
        end else begin
            m_done = 1'b0;
            if (bus.load) build_frame(bus.din);
        end
        @(posedge ck);
        #2;
        cyc++;
        if (bus.done === 1'b1) done_log.push_back(cyc);
        check_outputs();
    endtask

    // Reset between edges: outputs must go idle without a clock.
    task automatic async_reset();
        #1;
        rs = 1'b1;
        #1;
        chk("rst_async_c",    {31'd0, bus.c},    32'd1);
        chk("rst_async_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_async_done", {31'd0, bus.done}, 32'd0);
        m_q.delete();
        m_done = 1'b0;
        step();
        rs = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d);
        bus.din  = d;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (F) step();
    endtask

    initial begin
        rs       = 1'b1;
        bus.load = 1'b0;
        bus.din  = '0;
        m_done   = 1'b0;

        // Reset held with load toggling.
        for (int i = 0; i < 4; i++) begin
            bus.load = i[0];
            bus.din  = W'($urandom);
            step();
        end
        rs       = 1'b0;
        bus.load = 1'b0;
        repeat (2) step();

        // Single frames, including the parity-distinguishing words.
        send(8'hA5);
        step();
        send(8'h01);
        step();

        // Load pulse during payload bit 3 is ignored.
        bus.din  = 8'h3C;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (6) step();
        bus.din  = 8'hFF;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.din  = '0;
        repeat (F + 3) step();

        // Back-to-back with load held high.
        done_log.delete();
        bus.din  = 8'h81;
        bus.load = 1'b1;
        step();
        bus.din  = 8'h7E;
        repeat (F + 1) step();
        bus.load = 1'b0;
        repeat (F + 2) step();
        chk("b2b_done_count", done_log.size(), 32'd2);
        if (done_log.size() == 2)
            chk("b2b_done_gap", done_log[1] - done_log[0], F + 1);

        // Reset during payload bit 5, then a clean frame.
        bus.din  = 8'h55;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (9) step();
        done_log.delete();
        async_reset();
        repeat (2) step();
        chk("rst_no_done", done_log.size(), 32'd0);
        send(8'h0F);
        step();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            bus.load = ($urandom_range(0, 3) == 0);
            bus.din  = W'($urandom);
            if ($urandom_range(0, 149) == 0) async_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
